// File: rtl/fifo_sync_bytevar.sv
// Single-clock byte-granular FIFO converting DW_W-bit writes into DW_R-bit reads,
// with a variable byte count per transfer, a registered read port and sticky error flags.
module fifo_sync_bytevar #(
  parameter int DW_W      = 64,
  parameter int DW_R      = 32,
  parameter int SIZE      = 2048,
  parameter int AF_THRESH = SIZE - 2 * ((DW_W + 7) / 8),
  localparam int DW_W_BYTE = (DW_W + 7) / 8,
  localparam int DW_R_BYTE = (DW_R + 7) / 8,
  localparam int WN_W      = $clog2(DW_W_BYTE + 1),
  localparam int RN_W      = $clog2(DW_R_BYTE + 1),
  localparam int PTR_W     = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              w_req,
  input  logic [WN_W-1:0]   w_nbytes,
  input  logic [DW_W-1:0]   data_i,
  output logic              w_ack,
  input  logic              r_req,
  input  logic [RN_W-1:0]   r_nbytes,
  output logic              r_ack,
  output logic [DW_R-1:0]   data_o,
  output logic              r_vld,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [PTR_W:0]    byte_cnt,
  output logic              err_ovf,
  output logic              err_udf
);

  // Handshake: a request with a nonzero byte count is accepted (w_ack/r_ack high,
  // combinationally in the same cycle) only if the count is within the port width and
  // fits the space/occupancy seen at the start of the cycle; otherwise it is dropped
  // and the matching sticky error flag is set. Zero-length requests are ignored.

  localparam int CW = PTR_W + 1;
  localparam logic [WN_W-1:0] W_MAX  = WN_W'(DW_W_BYTE);
  localparam logic [RN_W-1:0] R_MAX  = RN_W'(DW_R_BYTE);
  localparam logic [CW-1:0]   SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0]   AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0]   FULL_C = CW'(DW_W_BYTE);

  logic [7:0]             mem [SIZE];
  logic [PTR_W-1:0]       w_ptr;
  logic [PTR_W-1:0]       r_ptr;
  logic [CW-1:0]          free;
  logic [CW-1:0]          w_len;
  logic [CW-1:0]          r_len;
  logic [CW-1:0]          cnt_next;
  logic [8*DW_W_BYTE-1:0] w_word;
  logic [8*DW_R_BYTE-1:0] r_word;
  logic                   w_try;
  logic                   r_try;

  always_comb begin
    free     = SIZE_C - byte_cnt;
    w_len    = CW'(w_nbytes);
    r_len    = CW'(r_nbytes);
    w_try    = w_req && (w_nbytes != '0);
    r_try    = r_req && (r_nbytes != '0);
    w_ack    = !flush && w_try && (w_nbytes <= W_MAX) && (w_len <= free);
    r_ack    = !flush && r_try && (r_nbytes <= R_MAX) && (r_len <= byte_cnt);
    cnt_next = byte_cnt + (w_ack ? w_len : '0) - (r_ack ? r_len : '0);
  end

  assign full        = free < FULL_C;
  assign empty       = byte_cnt == '0;
  assign almost_full = byte_cnt >= AF_C;

  // Pad the write word to whole bytes so a partial top byte can still be addressed.
  always_comb begin
    w_word             = '0;
    w_word[DW_W-1:0]   = data_i;
  end

  // Pointer arithmetic is PTR_W bits wide, so each byte wraps independently.
  always_ff @(posedge clk) begin
    if (w_ack) begin
      for (int j = 0; j < DW_W_BYTE; j++) begin
        if (WN_W'(j) < w_nbytes) mem[w_ptr + PTR_W'(j)] <= w_word[8*j +: 8];
      end
    end
  end

  always_comb begin
    r_word = '0;
    for (int i = 0; i < DW_R_BYTE; i++) begin
      if (RN_W'(i) < r_nbytes) r_word[8*i +: 8] = mem[r_ptr + PTR_W'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      byte_cnt <= '0;
      data_o   <= '0;
      r_vld    <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else if (flush) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      byte_cnt <= '0;
      r_vld    <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      byte_cnt <= cnt_next;
      r_vld    <= r_ack;
      if (w_ack) w_ptr <= w_ptr + PTR_W'(w_nbytes);
      if (r_ack) begin
        r_ptr  <= r_ptr + PTR_W'(r_nbytes);
        data_o <= r_word[DW_R-1:0];
      end
      if (w_try && !w_ack) err_ovf <= 1'b1;
      if (r_try && !r_ack) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sync_bytevar.sv
// Directed bench for fifo_sync_bytevar with a 16-byte store, 64-bit writes and 32-bit reads.
module tb_fifo_sync_bytevar;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        w_req;
  logic [3:0]  w_nbytes;
  logic [63:0] data_i;
  logic        w_ack;
  logic        r_req;
  logic [2:0]  r_nbytes;
  logic        r_ack;
  logic [31:0] data_o;
  logic        r_vld;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [4:0]  byte_cnt;
  logic        err_ovf;
  logic        err_udf;

  logic        w_ack_s;
  logic        r_ack_s;
  int          checks;
  int          errors;

  fifo_sync_bytevar #(
    .DW_W(64), .DW_R(32), .SIZE(16), .AF_THRESH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .w_req(w_req), .w_nbytes(w_nbytes), .data_i(data_i), .w_ack(w_ack),
    .r_req(r_req), .r_nbytes(r_nbytes), .r_ack(r_ack),
    .data_o(data_o), .r_vld(r_vld),
    .full(full), .empty(empty), .almost_full(almost_full), .byte_cnt(byte_cnt),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs just after a rising edge, capture the
  // combinational acks mid-cycle, then return 1 ns after the next rising edge.
  task automatic step(input logic fl, input logic wr, input logic [3:0] wn,
                      input logic [63:0] wd, input logic rd, input logic [2:0] rn);
    flush = fl; w_req = wr; w_nbytes = wn; data_i = wd; r_req = rd; r_nbytes = rn;
    #2;
    w_ack_s = w_ack;
    r_ack_s = r_ack;
    @(posedge clk); #1;
    flush = 1'b0; w_req = 1'b0; r_req = 1'b0; w_nbytes = '0; r_nbytes = '0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0);
  endtask

  task automatic wr(input logic [3:0] n, input logic [63:0] d);
    step(1'b0, 1'b1, n, d, 1'b0, 3'd0);
  endtask

  task automatic rd(input logic [2:0] n);
    step(1'b0, 1'b0, 4'd0, 64'h0, 1'b1, n);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; w_req = 1'b0; r_req = 1'b0;
    w_nbytes = '0; r_nbytes = '0; data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b exp 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %0b exp 0", almost_full); end
    checks++; if (byte_cnt !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", byte_cnt); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", data_o); end
    checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %0b exp 0", r_vld); end
    checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b exp 00", {err_ovf, err_udf}); end
    // Zero-length requests do nothing
    step(1'b0, 1'b1, 4'd0, 64'hFF, 1'b1, 3'd0);
    checks++; if ({w_ack_s, r_ack_s} !== 2'b00) begin errors++; $display("FAIL zero_ack: got %b exp 00", {w_ack_s, r_ack_s}); end
    checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL zero_err: got %b exp 00", {err_ovf, err_udf}); end
  endtask

  task automatic test_basic();
    wr(4'd8, 64'h0706050403020100);
    checks++; if (w_ack_s !== 1'b1) begin errors++; $display("FAIL basic_wack: got %0b exp 1", w_ack_s); end
    checks++; if (byte_cnt !== 5'd8) begin errors++; $display("FAIL basic_cnt8: got %0d exp 8", byte_cnt); end
    checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_pre: got %0b exp 0", r_vld); end
    rd(3'd4);
    checks++; if (r_ack_s !== 1'b1) begin errors++; $display("FAIL basic_rack: got %0b exp 1", r_ack_s); end
    checks++; if (r_vld !== 1'b1) begin errors++; $display("FAIL basic_vld1: got %0b exp 1", r_vld); end
    checks++; if (data_o !== 32'h03020100) begin errors++; $display("FAIL basic_d0: got %h exp 03020100", data_o); end
    rd(3'd4);
    checks++; if (data_o !== 32'h07060504) begin errors++; $display("FAIL basic_d1: got %h exp 07060504", data_o); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %0b exp 1", empty); end
    idle();
    checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_drop: got %0b exp 0", r_vld); end
    checks++; if (data_o !== 32'h07060504) begin errors++; $display("FAIL basic_hold: got %h exp 07060504", data_o); end
  endtask

  task automatic test_underflow();
    wr(4'd3, 64'hFFFFFFFFFFCCBBAA);
    checks++; if (byte_cnt !== 5'd3) begin errors++; $display("FAIL udf_cnt3: got %0d exp 3", byte_cnt); end
    rd(3'd4);
    checks++; if (r_ack_s !== 1'b0) begin errors++; $display("FAIL udf_rack: got %0b exp 0", r_ack_s); end
    checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL udf_flag: got %0b exp 1", err_udf); end
    checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL udf_vld: got %0b exp 0", r_vld); end
    rd(3'd3);
    checks++; if (data_o !== 32'h00CCBBAA) begin errors++; $display("FAIL udf_data: got %h exp 00ccbbaa", data_o); end
    checks++; if (byte_cnt !== 5'd0) begin errors++; $display("FAIL udf_cnt0: got %0d exp 0", byte_cnt); end
    checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL udf_sticky: got %0b exp 1", err_udf); end
    do_flush();
  endtask

  task automatic test_fill();
    wr(4'd8, 64'h0706050403020100);
    checks++; if ({almost_full, full} !== 2'b00) begin errors++; $display("FAIL fill_flags8: got %b exp 00", {almost_full, full}); end
    wr(4'd6, 64'h00000D0C0B0A0908);
    checks++; if (byte_cnt !== 5'd14) begin errors++; $display("FAIL fill_cnt14: got %0d exp 14", byte_cnt); end
    checks++; if ({almost_full, full} !== 2'b11) begin errors++; $display("FAIL fill_flags14: got %b exp 11", {almost_full, full}); end
    wr(4'd3, 64'h0000000000EEDDCC);
    checks++; if (w_ack_s !== 1'b0) begin errors++; $display("FAIL fill_wack3: got %0b exp 0", w_ack_s); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %0b exp 1", err_ovf); end
    checks++; if (byte_cnt !== 5'd14) begin errors++; $display("FAIL fill_cnt_hold: got %0d exp 14", byte_cnt); end
    wr(4'd2, 64'h000000000000F1F0);
    checks++; if (w_ack_s !== 1'b1) begin errors++; $display("FAIL fill_wack2: got %0b exp 1", w_ack_s); end
    checks++; if (byte_cnt !== 5'd16) begin errors++; $display("FAIL fill_cnt16: got %0d exp 16", byte_cnt); end
    do_flush();
  endtask

  task automatic test_wrap();
    wr(4'd8, 64'h0706050403020100);
    wr(4'd6, 64'h00000D0C0B0A0908);
    rd(3'd4);
    rd(3'd4);
    rd(3'd4);
    checks++; if (data_o !== 32'h0B0A0908) begin errors++; $display("FAIL wrap_pre3: got %h exp 0b0a0908", data_o); end
    rd(3'd2);
    checks++; if (data_o !== 32'h00000D0C) begin errors++; $display("FAIL wrap_pre4: got %h exp 00000d0c", data_o); end
    wr(4'd8, 64'h1716151413121110);
    checks++; if (w_ack_s !== 1'b1) begin errors++; $display("FAIL wrap_wack: got %0b exp 1", w_ack_s); end
    rd(3'd4);
    checks++; if (data_o !== 32'h13121110) begin errors++; $display("FAIL wrap_d0: got %h exp 13121110", data_o); end
    rd(3'd4);
    checks++; if (data_o !== 32'h17161514) begin errors++; $display("FAIL wrap_d1: got %h exp 17161514", data_o); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b exp 1", empty); end
    // Oversize write into an empty store is still rejected
    wr(4'd9, 64'h1111111111111111);
    checks++; if (w_ack_s !== 1'b0) begin errors++; $display("FAIL wrap_oversize_ack: got %0b exp 0", w_ack_s); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL wrap_oversize_ovf: got %0b exp 1", err_ovf); end
  endtask

  task automatic test_back_to_back();
    wr(4'd6, 64'h0000252423222120);
    checks++; if (byte_cnt !== 5'd6) begin errors++; $display("FAIL b2b_cnt6: got %0d exp 6", byte_cnt); end
    step(1'b0, 1'b1, 4'd8, 64'h2F2E2D2C2B2A2928, 1'b1, 3'd4);
    checks++; if ({w_ack_s, r_ack_s} !== 2'b11) begin errors++; $display("FAIL b2b_acks: got %b exp 11", {w_ack_s, r_ack_s}); end
    checks++; if (byte_cnt !== 5'd10) begin errors++; $display("FAIL b2b_cnt10: got %0d exp 10", byte_cnt); end
    checks++; if (data_o !== 32'h23222120) begin errors++; $display("FAIL b2b_data: got %h exp 23222120", data_o); end
    rd(3'd5);
    checks++; if (r_ack_s !== 1'b0) begin errors++; $display("FAIL b2b_oversize_rack: got %0b exp 0", r_ack_s); end
    checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL b2b_udf: got %0b exp 1", err_udf); end
    step(1'b1, 1'b1, 4'd2, 64'h0000000000004342, 1'b0, 3'd0);
    checks++; if (w_ack_s !== 1'b0) begin errors++; $display("FAIL flush_wack: got %0b exp 0", w_ack_s); end
    checks++; if (byte_cnt !== 5'd0) begin errors++; $display("FAIL flush_cnt: got %0d exp 0", byte_cnt); end
    checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL flush_err: got %b exp 00", {err_ovf, err_udf}); end
    checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL flush_vld: got %0b exp 0", r_vld); end
    checks++; if (data_o !== 32'h23222120) begin errors++; $display("FAIL flush_hold: got %h exp 23222120", data_o); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %0b exp 1", empty); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w_ack_s = 1'b0;
    r_ack_s = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_fill();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
